// File: rtl/instruc_fetch.sv
// rtl/instruc_fetch.sv - instruction fetch stage with redirect draining and single-entry output buffer
//
// Purpose:
//   Keeps the fetch PC, issues one instruction-memory request at a time and
//   buffers the returned word for the IF/ID boundary. A redirect that arrives
//   while a request is still outstanding parks the new target and drains the
//   stale response before fetching from the target.
//
// Ports:
//   clock          - single clock, all state updates on the rising edge
//   reset          - synchronous, active-high reset
//   imem_req       - memory request, high whenever not in reset
//   imem_addr      - fetch address (the PC register), stable while imem_req is high
//   imem_valid     - one-cycle response strobe completing the outstanding request
//   imem_rdata     - instruction word, valid with imem_valid
//   stall          - downstream cannot take a new instruction this cycle
//   branch_taken   - redirect request from a later stage
//   branch_target  - redirect address, low two bits forced to zero
//   out_pc_address - PC of the buffered instruction
//   output_instruc - buffered instruction word
//   out_valid      - buffer holds a live instruction

module instruc_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_valid,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic [31:0] out_pc_address,
    output logic [31:0] output_instruc,
    output logic        out_valid
);

    typedef enum logic {
        S_FETCH = 1'b0,
        S_DRAIN = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [31:0] r_pc;
    logic [31:0] w_pc_next;
    logic [31:0] r_pending;
    logic [31:0] w_pending_next;
    logic [31:0] r_out_pc;
    logic [31:0] w_out_pc_next;
    logic [31:0] r_out_instr;
    logic [31:0] w_out_instr_next;
    logic        r_out_valid;
    logic        w_out_valid_next;

    logic [31:0] w_target;
    logic [31:0] w_pc_plus4;
    logic        w_consume;
    logic        w_accept;

    // Masking (rather than slicing) keeps every bit of branch_target in use.
    assign w_target   = branch_target & 32'hFFFF_FFFC;
    assign w_pc_plus4 = r_pc + 32'd4;

    // The buffer drains when it is live and downstream is not stalling; a
    // response is accepted only if the buffer is empty or draining this edge.
    assign w_consume = r_out_valid & ~stall;
    assign w_accept  = (r_state == S_FETCH) & imem_valid & ~branch_taken
                     & (~r_out_valid | ~stall);

    assign imem_req       = ~reset;
    assign imem_addr      = r_pc;
    assign out_pc_address = r_out_pc;
    assign output_instruc = r_out_instr;
    assign out_valid      = r_out_valid;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= S_FETCH;
            r_pc        <= RESET_PC;
            r_pending   <= 32'h0000_0000;
            r_out_pc    <= 32'h0000_0000;
            r_out_instr <= 32'h0000_0000;
            r_out_valid <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_pc        <= w_pc_next;
            r_pending   <= w_pending_next;
            r_out_pc    <= w_out_pc_next;
            r_out_instr <= w_out_instr_next;
            r_out_valid <= w_out_valid_next;
        end
    end

    always_comb begin
        w_state_next     = r_state;
        w_pc_next        = r_pc;
        w_pending_next   = r_pending;
        w_out_pc_next    = r_out_pc;
        w_out_instr_next = r_out_instr;
        w_out_valid_next = r_out_valid;

        if (branch_taken) begin
            // Flush wins over stall and accept; whatever is buffered or in
            // flight now belongs to the wrong path.
            w_out_valid_next = 1'b0;
            if (imem_valid) begin
                // The outstanding request completes at this edge, so the new
                // target can be requested directly from either state.
                w_pc_next    = w_target;
                w_state_next = S_FETCH;
            end else begin
                // Request still outstanding: keep the address stable, park
                // the target (newest redirect overwrites an older one).
                w_pending_next = w_target;
                w_state_next   = S_DRAIN;
            end
        end else begin
            case (r_state)
                S_FETCH: begin
                    if (w_accept) begin
                        w_out_pc_next    = r_pc;
                        w_out_instr_next = imem_rdata;
                        w_out_valid_next = 1'b1;
                        w_pc_next        = w_pc_plus4;
                    end else if (w_consume) begin
                        w_out_valid_next = 1'b0;
                    end
                    // A response that is neither accepted nor redirected is
                    // dropped; PC is unchanged so the same address is re-requested.
                end
                S_DRAIN: begin
                    if (w_consume) begin
                        w_out_valid_next = 1'b0;
                    end
                    if (imem_valid) begin
                        // Stale response discarded; start fetching the target.
                        w_pc_next    = r_pending;
                        w_state_next = S_FETCH;
                    end
                end
                default: begin
                    w_state_next = S_FETCH;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instruc_fetch.sv
// tb/tb_instruc_fetch.sv - self-checking bench for instruc_fetch

module tb_instruc_fetch;

    logic        clock = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_valid;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic [31:0] out_pc_address;
    logic [31:0] output_instruc;
    logic        out_valid;

    logic        b_reset;
    logic        b_req;
    logic [31:0] b_addr;
    logic        b_valid;
    logic [31:0] b_rdata;
    logic [31:0] b_out_pc;
    logic [31:0] b_out_instr;
    logic        b_out_valid;

    int n_vec = 0;
    int n_err = 0;

    // Behavioural model state
    logic [31:0] m_pc, m_pend, m_opc, m_oin;
    logic        m_drain, m_ov;

    always #5 clock = ~clock;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    assign imem_rdata = mem_word(imem_addr);
    assign b_rdata    = mem_word(b_addr);

    instruc_fetch #(.RESET_PC(32'h0000_0000)) dut (
        .clock(clock), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_valid(imem_valid), .imem_rdata(imem_rdata), .stall(stall),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .out_pc_address(out_pc_address), .output_instruc(output_instruc),
        .out_valid(out_valid)
    );

    instruc_fetch #(.RESET_PC(32'hFFFF_FFF8)) dut_wrap (
        .clock(clock), .reset(b_reset), .imem_req(b_req), .imem_addr(b_addr),
        .imem_valid(b_valid), .imem_rdata(b_rdata), .stall(1'b0),
        .branch_taken(1'b0), .branch_target(32'h0),
        .out_pc_address(b_out_pc), .output_instruc(b_out_instr),
        .out_valid(b_out_valid)
    );

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic apply_reset;
        reset         = 1'b1;
        imem_valid    = 1'($urandom);
        stall         = 1'($urandom);
        branch_taken  = 1'($urandom);
        branch_target = $urandom;
        tick();
        reset        = 1'b0;
        imem_valid   = 1'b0;
        stall        = 1'b0;
        branch_taken = 1'b0;
    endtask

    // One edge of the fetch stage, stated in terms of its rules: a redirect
    // either lands now (response present) or is parked until the stale one
    // returns; otherwise the buffer takes a response only if it has room.
    task automatic model_edge;
        logic [31:0] tgt;
        tgt = {branch_target[31:2], 2'b00};
        if (reset) begin
            m_pc = 32'h0; m_pend = 32'h0; m_drain = 1'b0;
            m_opc = 32'h0; m_oin = 32'h0; m_ov = 1'b0;
        end else if (branch_taken) begin
            m_ov = 1'b0;
            if (imem_valid) begin
                m_pc = tgt; m_drain = 1'b0;
            end else begin
                m_pend = tgt; m_drain = 1'b1;
            end
        end else if (m_drain) begin
            if (m_ov && !stall) m_ov = 1'b0;
            if (imem_valid) begin
                m_pc = m_pend; m_drain = 1'b0;
            end
        end else if (imem_valid && (!m_ov || !stall)) begin
            m_opc = m_pc; m_oin = mem_word(m_pc); m_ov = 1'b1;
            m_pc  = m_pc + 32'd4;
        end else if (m_ov && !stall) begin
            m_ov = 1'b0;
        end
    endtask

    task automatic test_reset;
        apply_reset();
        reset = 1'b1;
        tick();
        n_vec++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL reset_req: got %b expected 0", imem_req); end
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
        n_vec++; if (out_pc_address !== 32'h0) begin n_err++; $display("FAIL reset_pc: got %h expected 0", out_pc_address); end
        n_vec++; if (output_instruc !== 32'h0) begin n_err++; $display("FAIL reset_instr: got %h expected 0", output_instruc); end
        reset = 1'b0;
        #1;
        n_vec++; if (imem_req !== 1'b1) begin n_err++; $display("FAIL post_reset_req: got %b expected 1", imem_req); end
        n_vec++; if (imem_addr !== 32'h0) begin n_err++; $display("FAIL post_reset_addr: got %h expected 0", imem_addr); end
    endtask

    task automatic test_zero_wait;
        apply_reset();
        imem_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL zw_valid[%0d]: got %b expected 1", k, out_valid); end
            n_vec++; if (out_pc_address !== 32'(4 * k)) begin n_err++; $display("FAIL zw_pc[%0d]: got %h expected %h", k, out_pc_address, 32'(4 * k)); end
            n_vec++; if (output_instruc !== mem_word(32'(4 * k))) begin n_err++; $display("FAIL zw_instr[%0d]: got %h expected %h", k, output_instruc, mem_word(32'(4 * k))); end
        end
        imem_valid = 1'b0;
    endtask

    task automatic test_stall;
        apply_reset();
        imem_valid = 1'b1;
        tick(); tick(); tick();
        stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            n_vec++; if (out_pc_address !== 32'd8 || out_valid !== 1'b1) begin n_err++; $display("FAIL stall_hold[%0d]: got pc %h v %b expected pc 8 v 1", k, out_pc_address, out_valid); end
            n_vec++; if (imem_addr !== 32'd12) begin n_err++; $display("FAIL stall_addr[%0d]: got %h expected c", k, imem_addr); end
        end
        stall = 1'b0;
        tick();
        n_vec++; if (out_pc_address !== 32'd12 || out_valid !== 1'b1) begin n_err++; $display("FAIL stall_release: got pc %h v %b expected pc c v 1", out_pc_address, out_valid); end
        imem_valid = 1'b0;
    endtask

    task automatic test_branch_drain;
        apply_reset();
        imem_valid = 1'b1;
        tick(); tick();
        imem_valid    = 1'b0;
        branch_taken  = 1'b1;
        branch_target = 32'h0000_0103;
        tick();
        branch_taken = 1'b0;
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL br_flush: got %b expected 0", out_valid); end
        n_vec++; if (imem_addr !== 32'd8) begin n_err++; $display("FAIL br_addr_hold: got %h expected 8", imem_addr); end
        for (int k = 0; k < 2; k++) begin
            tick();
            n_vec++; if (imem_addr !== 32'd8 || out_valid !== 1'b0) begin n_err++; $display("FAIL br_drain[%0d]: got addr %h v %b expected addr 8 v 0", k, imem_addr, out_valid); end
        end
        imem_valid = 1'b1;
        tick();
        n_vec++; if (imem_addr !== 32'h100 || out_valid !== 1'b0) begin n_err++; $display("FAIL br_target_addr: got addr %h v %b expected addr 100 v 0", imem_addr, out_valid); end
        tick();
        n_vec++; if (out_pc_address !== 32'h100 || out_valid !== 1'b1) begin n_err++; $display("FAIL br_first_pc: got pc %h v %b expected pc 100 v 1", out_pc_address, out_valid); end
        imem_valid = 1'b0;
    endtask

    task automatic test_flush_beats_stall;
        logic [31:0] tgt;
        tgt = {$urandom_range(32'h3FFF_FFFF, 0) , 2'b00} ;
        apply_reset();
        imem_valid = 1'b1;
        tick(); tick();
        stall         = 1'b1;
        branch_taken  = 1'b1;
        branch_target = tgt;
        tick();
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL flush_stall_valid: got %b expected 0", out_valid); end
        n_vec++; if (imem_addr !== tgt) begin n_err++; $display("FAIL flush_stall_addr: got %h expected %h", imem_addr, tgt); end
        stall = 1'b0; branch_taken = 1'b0; imem_valid = 1'b0;
    endtask

    task automatic test_reset_in_drain;
        apply_reset();
        imem_valid = 1'b1;
        tick();
        imem_valid    = 1'b0;
        branch_taken  = 1'b1;
        branch_target = 32'h0000_0200;
        tick();
        branch_taken = 1'b0;
        reset        = 1'b1;
        imem_valid   = 1'b1;
        tick();
        n_vec++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL rd_req_in_reset: got %b expected 0", imem_req); end
        reset      = 1'b0;
        imem_valid = 1'b0;
        #1;
        n_vec++; if (imem_req !== 1'b1 || imem_addr !== 32'h0 || out_valid !== 1'b0) begin n_err++; $display("FAIL rd_after_reset: got req %b addr %h v %b expected req 1 addr 0 v 0", imem_req, imem_addr, out_valid); end
        imem_valid = 1'b1;
        tick();
        n_vec++; if (out_pc_address !== 32'h0 || out_valid !== 1'b1 || imem_addr !== 32'h4) begin n_err++; $display("FAIL rd_no_pending: got pc %h v %b addr %h expected pc 0 v 1 addr 4", out_pc_address, out_valid, imem_addr); end
        imem_valid = 1'b0;
    endtask

    task automatic test_wrap;
        logic [31:0] exp_pc [3];
        exp_pc[0] = 32'hFFFF_FFF8; exp_pc[1] = 32'hFFFF_FFFC; exp_pc[2] = 32'h0000_0000;
        b_reset = 1'b1;
        tick();
        b_reset = 1'b0;
        #1;
        n_vec++; if (b_addr !== 32'hFFFF_FFF8) begin n_err++; $display("FAIL wrap_first_addr: got %h expected fffffff8", b_addr); end
        for (int k = 0; k < 3; k++) begin
            tick();
            n_vec++; if (b_out_pc !== exp_pc[k] || b_out_valid !== 1'b1) begin n_err++; $display("FAIL wrap_pc[%0d]: got pc %h v %b expected pc %h v 1", k, b_out_pc, b_out_valid, exp_pc[k]); end
            n_vec++; if (b_out_instr !== mem_word(exp_pc[k])) begin n_err++; $display("FAIL wrap_instr[%0d]: got %h expected %h", k, b_out_instr, mem_word(exp_pc[k])); end
        end
    endtask

    task automatic test_random;
        reset = 1'b1;
        model_edge();
        tick();
        for (int k = 0; k < 3000; k++) begin
            reset         = ($urandom_range(63, 0) == 0);
            stall         = ($urandom_range(2, 0) == 0);
            branch_taken  = ($urandom_range(7, 0) == 0);
            branch_target = $urandom;
            imem_valid    = 1'($urandom);
            model_edge();
            tick();
            n_vec++; if (imem_req !== !reset) begin n_err++; $display("FAIL rnd_req[%0d]: got %b expected %b", k, imem_req, !reset); end
            n_vec++; if (imem_addr !== m_pc) begin n_err++; $display("FAIL rnd_addr[%0d]: got %h expected %h", k, imem_addr, m_pc); end
            n_vec++; if (out_valid !== m_ov) begin n_err++; $display("FAIL rnd_valid[%0d]: got %b expected %b", k, out_valid, m_ov); end
            n_vec++; if (out_pc_address !== m_opc || output_instruc !== m_oin) begin n_err++; $display("FAIL rnd_buf[%0d]: got pc %h ins %h expected pc %h ins %h", k, out_pc_address, output_instruc, m_opc, m_oin); end
        end
        reset = 1'b0; stall = 1'b0; branch_taken = 1'b0; imem_valid = 1'b0;
    endtask

    initial begin
        reset = 1'b1; imem_valid = 1'b0; stall = 1'b0;
        branch_taken = 1'b0; branch_target = 32'h0;
        b_reset = 1'b1; b_valid = 1'b1;
        tick();
        test_reset();
        test_zero_wait();
        test_stall();
        test_branch_drain();
        test_flush_beats_stall();
        test_reset_in_drain();
        test_wrap();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/instruc_fetch.md
INSTRUC_FETCH -- requirements
Module: instruc_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h00000000, giving the PC loaded on reset (bits [1:0] SHALL be zero).
REQ-002 SHALL have port clock, input, 1 bit: single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port imem_req, output, 1 bit: instruction memory request, held high until the response arrives.
REQ-005 SHALL have port imem_addr, output, 32 bits: fetch address, stable while imem_req is high.
REQ-006 SHALL have port imem_valid, input, 1 bit: one-cycle response strobe; completes the outstanding request at that edge.
REQ-007 SHALL have port imem_rdata, input, 32 bits: instruction word, valid when imem_valid=1.
REQ-008 SHALL have port stall, input, 1 bit: downstream (IF/ID) cannot take a new instruction this cycle.
REQ-009 SHALL have port branch_taken, input, 1 bit: redirect request from a later stage.
REQ-010 SHALL have port branch_target, input, 32 bits: redirect address; bits [1:0] are ignored and treated as 0.
REQ-011 SHALL have port out_pc_address, output, 32 bits: registered PC of the buffered instruction.
REQ-012 SHALL have port output_instruc, output, 32 bits: registered instruction word.
REQ-013 SHALL have port out_valid, output, 1 bit: out_pc_address/output_instruc hold a live instruction.

Function
REQ-014 SHALL keep a PC register and a 2-state FSM: FETCH (normal request) and DRAIN (stale request outstanding after a redirect).
REQ-015 SHALL drive imem_addr = PC register and imem_req = 1 in both FETCH and DRAIN when reset=0, and imem_req = 0 while reset=1.
REQ-016 SHALL treat consume as out_valid=1 and stall=0 at an edge.
REQ-017 SHALL treat accept as FETCH, imem_valid=1, branch_taken=0 and (out_valid=0 or stall=0) at an edge: out_pc_address<=PC, output_instruc<=imem_rdata, out_valid<=1, PC<=PC+4.
REQ-018 SHALL give zero-wait memory a throughput of one instruction per cycle, with one cycle from imem_valid to out_valid.
REQ-019 SHALL discard the response when FETCH and imem_valid=1 but out_valid=1 and stall=1, leave PC unchanged, and re-request the same address next cycle.
REQ-020 SHALL clear out_valid on consume without accept, and SHALL leave the buffer unchanged on no consume and no accept.
REQ-021 SHALL compute PC+4 modulo 2^32, so 32'hFFFFFFFC wraps to 32'h00000000.
REQ-022 SHALL give branch_taken priority over stall and accept, and SHALL force out_valid<=0 at any edge with branch_taken=1.
REQ-023 SHALL, on redirect in FETCH with imem_valid=1, discard the response, set PC<={branch_target[31:2],2'b00}, and stay in FETCH.
REQ-024 SHALL, on redirect in FETCH with imem_valid=0, save the aligned target in a pending register, keep PC (address stable), and go to DRAIN.
REQ-025 SHALL, in DRAIN, discard every response; on imem_valid it SHALL set PC<=pending target and go to FETCH.
REQ-026 SHALL, on a redirect during DRAIN, overwrite the pending target (newest wins); a redirect coinciding with imem_valid in DRAIN SHALL set PC to the new target directly and go to FETCH.
REQ-027 SHALL never expose an instruction fetched before a redirect on out_valid after that redirect's edge.

Reset
REQ-028 SHALL, on reset=1 at an edge, set PC<=RESET_PC, FSM<=FETCH, pending target<=0, out_pc_address<=0, output_instruc<=0 and out_valid<=0, regardless of state or other inputs.
REQ-029 SHALL ignore imem_valid, branch_taken and stall during reset, and SHALL request RESET_PC on the first cycle after reset (memory reset concurrently, so no stale response is in flight).

Verification
REQ-030 SHALL check reset then zero-wait memory (imem_valid=1 every cycle, stall=0) -> out_pc_address 0,4,8,12 on consecutive cycles with out_valid=1 from the second cycle.
REQ-031 SHALL check stall=1 for 3 cycles with buffer holding PC 8 -> outputs frozen at PC 8, imem_addr stays 12, responses discarded; after stall=0 the next buffered PC is 12.
REQ-032 SHALL check branch_taken=1, target 32'h00000103, in FETCH with imem_valid=0 -> out_valid=0 next cycle, DRAIN entered, imem_addr unchanged until imem_valid, then imem_addr=32'h00000100 and the first output PC is 32'h100.
REQ-033 SHALL check branch_taken together with stall=1 and out_valid=1 -> out_valid=0 next cycle (flush beats stall).
REQ-034 SHALL check RESET_PC=32'hFFFFFFF8 with zero-wait memory -> output PCs FFFFFFF8, FFFFFFFC, 00000000.
REQ-035 SHALL check reset asserted while in DRAIN -> next cycle imem_req=1, imem_addr=RESET_PC, out_valid=0, and the pending target is not used.
